// File: rtl/hs_npu_pkg.sv
// ============================================================================
//  Module      : hs_npu_pkg
//  Description : Shared types and constants for the NPU layer sequencer:
//                layer descriptor layout, flag bit positions, sequencer
//                state encoding and a descriptor word-insert helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hs_npu_pkg;

    localparam int DESC_WORDS = 8;

    // Bit positions inside descriptor word 4 (flags)
    localparam int DESC_FLAG_REUSE_INPUTS  = 0;
    localparam int DESC_FLAG_REUSE_WEIGHTS = 1;
    localparam int DESC_FLAG_SAVE_OUTPUTS  = 2;
    localparam int DESC_FLAG_USE_BIAS      = 3;
    localparam int DESC_FLAG_USE_SUM       = 4;
    localparam int DESC_FLAG_ACT_SELECT    = 5;
    localparam int DESC_FLAG_LAST          = 31;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_FETCH = 3'd1,   // descriptor fetcher active (request/wait phases)
        SEQ_ISSUE = 3'd2,
        SEQ_RUN   = 3'd3,
        SEQ_DONE  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic last;
        logic activation_select;
        logic use_sum;
        logic use_bias;
        logic save_outputs;
        logic reuse_weights;
        logic reuse_inputs;
    } npu_layer_flags_t;

    typedef struct packed {
        logic [31:0]      num_input_rows;
        logic [31:0]      num_input_columns;
        logic [31:0]      num_weight_rows;
        logic [31:0]      num_weight_columns;
        npu_layer_flags_t flags;
        logic [31:0]      shift_amount;
        logic [31:0]      base_address;
        logic [31:0]      result_address;
    } npu_layer_desc_t;

    // Return descriptor d with word idx replaced by w (flags word decoded).
    function automatic npu_layer_desc_t desc_set_word(
        input npu_layer_desc_t d,
        input logic [2:0]      idx,
        input logic [31:0]     w
    );
        npu_layer_desc_t r;
        r = d;
        case (idx)
            3'd0: r.num_input_rows     = w;
            3'd1: r.num_input_columns  = w;
            3'd2: r.num_weight_rows    = w;
            3'd3: r.num_weight_columns = w;
            3'd4: begin
                r.flags.reuse_inputs      = w[DESC_FLAG_REUSE_INPUTS];
                r.flags.reuse_weights     = w[DESC_FLAG_REUSE_WEIGHTS];
                r.flags.save_outputs      = w[DESC_FLAG_SAVE_OUTPUTS];
                r.flags.use_bias          = w[DESC_FLAG_USE_BIAS];
                r.flags.use_sum           = w[DESC_FLAG_USE_SUM];
                r.flags.activation_select = w[DESC_FLAG_ACT_SELECT];
                r.flags.last              = w[DESC_FLAG_LAST];
            end
            3'd5: r.shift_amount       = w;
            3'd6: r.base_address       = w;
            default: r.result_address  = w;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hs_npu_desc_fetcher.sv
// ============================================================================
//  Module      : hs_npu_desc_fetcher
//  Description : Fetches one layer descriptor word by word over a
//                valid/ready request + response-valid read port. Keeps a
//                running byte pointer that continues across layers.
//  Ports       : i_start/i_load_base/i_base start a fetch (optionally
//                reloading the pointer), i_abort returns to idle,
//                o_req_*/i_req_ready request channel, i_rsp_* response,
//                o_desc/o_done deliver the complete descriptor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_npu_desc_fetcher
    import hs_npu_pkg::*;
#(
    parameter int NUM_WORDS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_load_base,
    input  logic [31:0]     i_base,
    input  logic            i_abort,
    output logic            o_req_valid,
    input  logic            i_req_ready,
    output logic [31:0]     o_req_addr,
    input  logic            i_rsp_valid,
    input  logic [31:0]     i_rsp_data,
    output npu_layer_desc_t o_desc,
    output logic            o_done
);

    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_REQ  = 2'd1;
    localparam logic [1:0] F_WAIT = 2'd2;

    localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

    logic [1:0]      r_state;
    logic [31:0]     r_ptr;
    logic [2:0]      r_idx;
    npu_layer_desc_t r_shadow;
    npu_layer_desc_t w_desc;
    logic            w_capture;

    assign w_capture   = (r_state == F_WAIT) && i_rsp_valid;
    // Shadow with the arriving word merged, so the final word is usable
    // on the same edge it is captured.
    assign w_desc      = desc_set_word(r_shadow, r_idx, i_rsp_data);
    assign o_desc      = w_desc;
    assign o_done      = w_capture && (r_idx == LAST_IDX);
    assign o_req_valid = (r_state == F_REQ);
    assign o_req_addr  = r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= F_IDLE;
            r_ptr    <= 32'd0;
            r_idx    <= 3'd0;
            r_shadow <= '0;
        end else if (i_abort) begin
            r_state <= F_IDLE;
        end else begin
            case (r_state)
                F_IDLE: begin
                    if (i_start) begin
                        r_state <= F_REQ;
                        r_idx   <= 3'd0;
                        if (i_load_base) begin
                            r_ptr <= i_base;
                        end
                    end
                end
                F_REQ: begin
                    // Pointer advances only on acceptance, so the address
                    // stays stable while the request is outstanding.
                    if (i_req_ready) begin
                        r_state <= F_WAIT;
                        r_ptr   <= r_ptr + 32'd4;
                    end
                end
                F_WAIT: begin
                    if (i_rsp_valid) begin
                        r_shadow <= w_desc;
                        if (r_idx == LAST_IDX) begin
                            r_state <= F_IDLE;
                        end else begin
                            r_state <= F_REQ;
                            r_idx   <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= F_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/hs_npu_layer_sequencer.sv
// ============================================================================
//  Module      : hs_npu_layer_sequencer
//  Description : Autonomous multi-layer scheduler. Fetches one descriptor
//                per layer, issues it to the NPU over exec valid/ready and
//                waits for the finished pulse, until the count is reached,
//                a descriptor carries the last flag, or abort is requested.
//  Ports       : start_i/abort_i/table_base_i/layer_count_i CPU control,
//                busy_o/done_o/layers_done_o status, desc_* read port,
//                exec_*/npu_finished_i NPU handshake, *_o layer config.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_npu_layer_sequencer
    import hs_npu_pkg::*;
#(
    parameter int DESC_WORDS  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [31:0]            table_base_i,
    input  logic [COUNT_WIDTH-1:0] layer_count_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [COUNT_WIDTH-1:0] layers_done_o,
    output logic                   desc_req_valid_o,
    input  logic                   desc_req_ready_i,
    output logic [31:0]            desc_req_addr_o,
    input  logic                   desc_rsp_valid_i,
    input  logic [31:0]            desc_rsp_data_i,
    output logic                   exec_valid_o,
    input  logic                   exec_ready_i,
    input  logic                   npu_finished_i,
    output logic [31:0]            num_input_rows_o,
    output logic [31:0]            num_input_columns_o,
    output logic [31:0]            num_weight_rows_o,
    output logic [31:0]            num_weight_columns_o,
    output logic [31:0]            shift_amount_o,
    output logic [31:0]            base_address_o,
    output logic [31:0]            result_address_o,
    output logic                   reuse_inputs_o,
    output logic                   reuse_weights_o,
    output logic                   save_outputs_o,
    output logic                   use_bias_o,
    output logic                   use_sum_o,
    output logic                   activation_select_o
);

    seq_state_e             r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_layers_done;
    logic                   r_abort_pend;
    npu_layer_desc_t        r_cfg;

    logic                   w_fetch_start;
    logic                   w_fetch_load;
    logic                   w_fetch_abort;
    logic                   w_fetch_done;
    npu_layer_desc_t        w_fetch_desc;
    logic [COUNT_WIDTH-1:0] w_layers_next;
    logic                   w_run_stop;

    assign w_layers_next = r_layers_done + COUNT_WIDTH'(1);
    // Abort arriving in the same cycle as finished also ends the run.
    assign w_run_stop    = r_abort_pend | abort_i | r_cfg.flags.last |
                           (w_layers_next == r_count);
    assign w_fetch_abort = abort_i && (r_state == SEQ_FETCH);

    always_comb begin
        w_fetch_start = 1'b0;
        w_fetch_load  = 1'b0;
        if (r_state == SEQ_IDLE && start_i && layer_count_i != '0) begin
            w_fetch_start = 1'b1;
            w_fetch_load  = 1'b1;
        end else if (r_state == SEQ_RUN && npu_finished_i && !w_run_stop) begin
            w_fetch_start = 1'b1;
        end
    end

    hs_npu_desc_fetcher #(
        .NUM_WORDS (DESC_WORDS)
    ) u_fetcher (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_fetch_start),
        .i_load_base (w_fetch_load),
        .i_base      (table_base_i),
        .i_abort     (w_fetch_abort),
        .o_req_valid (desc_req_valid_o),
        .i_req_ready (desc_req_ready_i),
        .o_req_addr  (desc_req_addr_o),
        .i_rsp_valid (desc_rsp_valid_i),
        .i_rsp_data  (desc_rsp_data_i),
        .o_desc      (w_fetch_desc),
        .o_done      (w_fetch_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SEQ_IDLE;
            r_count       <= '0;
            r_layers_done <= '0;
            r_abort_pend  <= 1'b0;
            r_cfg         <= '0;
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (start_i) begin
                        r_layers_done <= '0;
                        r_abort_pend  <= 1'b0;
                        r_count       <= layer_count_i;
                        r_state       <= (layer_count_i == '0) ? SEQ_DONE : SEQ_FETCH;
                    end
                end
                SEQ_FETCH: begin
                    if (abort_i) begin
                        r_state <= SEQ_DONE;
                    end else if (w_fetch_done) begin
                        r_cfg   <= w_fetch_desc;
                        r_state <= SEQ_ISSUE;
                    end
                end
                SEQ_ISSUE: begin
                    if (abort_i) begin
                        r_state <= SEQ_DONE;
                    end else if (exec_ready_i) begin
                        r_state <= SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    if (abort_i) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (npu_finished_i) begin
                        r_layers_done <= w_layers_next;
                        r_state       <= w_run_stop ? SEQ_DONE : SEQ_FETCH;
                    end
                end
                SEQ_DONE: r_state <= SEQ_IDLE;
                default:  r_state <= SEQ_IDLE;
            endcase
        end
    end

    assign busy_o        = (r_state != SEQ_IDLE);
    assign done_o        = (r_state == SEQ_DONE);
    assign exec_valid_o  = (r_state == SEQ_ISSUE);
    assign layers_done_o = r_layers_done;

    assign num_input_rows_o     = r_cfg.num_input_rows;
    assign num_input_columns_o  = r_cfg.num_input_columns;
    assign num_weight_rows_o    = r_cfg.num_weight_rows;
    assign num_weight_columns_o = r_cfg.num_weight_columns;
    assign shift_amount_o       = r_cfg.shift_amount;
    assign base_address_o       = r_cfg.base_address;
    assign result_address_o     = r_cfg.result_address;
    assign reuse_inputs_o       = r_cfg.flags.reuse_inputs;
    assign reuse_weights_o      = r_cfg.flags.reuse_weights;
    assign save_outputs_o       = r_cfg.flags.save_outputs;
    assign use_bias_o           = r_cfg.flags.use_bias;
    assign use_sum_o            = r_cfg.flags.use_sum;
    assign activation_select_o  = r_cfg.flags.activation_select;

endmodule

`default_nettype wire

// File: tb/tb_hs_npu_layer_sequencer.sv
// ============================================================================
//  Module      : tb_hs_npu_layer_sequencer
//  Description : Self-checking bench for hs_npu_layer_sequencer with a
//                descriptor memory model, an NPU model and scoreboards of
//                expected request addresses and layer configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hs_npu_layer_sequencer;

    localparam bit [31:0] TBASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [31:0] table_base_i;
    logic [15:0] layer_count_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] layers_done_o;
    logic        desc_req_valid_o;
    logic        desc_req_ready_i;
    logic [31:0] desc_req_addr_o;
    logic        desc_rsp_valid_i;
    logic [31:0] desc_rsp_data_i;
    logic        exec_valid_o;
    logic        exec_ready_i;
    logic        npu_finished_i;
    logic [31:0] num_input_rows_o, num_input_columns_o, num_weight_rows_o;
    logic [31:0] num_weight_columns_o, shift_amount_o, base_address_o, result_address_o;
    logic        reuse_inputs_o, reuse_weights_o, save_outputs_o;
    logic        use_bias_o, use_sum_o, activation_select_o;

    hs_npu_layer_sequencer dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_i              (start_i),
        .abort_i              (abort_i),
        .table_base_i         (table_base_i),
        .layer_count_i        (layer_count_i),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .layers_done_o        (layers_done_o),
        .desc_req_valid_o     (desc_req_valid_o),
        .desc_req_ready_i     (desc_req_ready_i),
        .desc_req_addr_o      (desc_req_addr_o),
        .desc_rsp_valid_i     (desc_rsp_valid_i),
        .desc_rsp_data_i      (desc_rsp_data_i),
        .exec_valid_o         (exec_valid_o),
        .exec_ready_i         (exec_ready_i),
        .npu_finished_i       (npu_finished_i),
        .num_input_rows_o     (num_input_rows_o),
        .num_input_columns_o  (num_input_columns_o),
        .num_weight_rows_o    (num_weight_rows_o),
        .num_weight_columns_o (num_weight_columns_o),
        .shift_amount_o       (shift_amount_o),
        .base_address_o       (base_address_o),
        .result_address_o     (result_address_o),
        .reuse_inputs_o       (reuse_inputs_o),
        .reuse_weights_o      (reuse_weights_o),
        .save_outputs_o       (save_outputs_o),
        .use_bias_o           (use_bias_o),
        .use_sum_o            (use_sum_o),
        .activation_select_o  (activation_select_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboards and model controls ----------------
    bit [31:0]  mem [0:63];
    bit [31:0]  exp_addr[$];
    bit [255:0] exp_cfg[$];

    bit rdy_rand   = 1'b0;
    int rsp_max    = 0;      // random response delay upper bound (0 = fixed)
    int rsp_fixed  = 0;
    bit exec_rand  = 1'b0;
    bit exec_hold  = 1'b0;
    int fin_max    = 0;      // random finished delay upper bound (0 = fixed)
    int fin_fixed  = 0;

    int acc_cnt = 0, exec_cnt = 0, exec_rise_cyc = 0, fin_cyc = 0, start_cyc = 0;
    bit pend = 1'b0;
    int pend_cnt = 0;
    bit [31:0] pend_data;
    bit fin_pend = 1'b0;
    int fin_left = 0;
    logic prev_ev = 1'b0;

    function automatic logic [255:0] cfg_now();
        return {num_input_rows_o, num_input_columns_o, num_weight_rows_o,
                num_weight_columns_o,
                {26'd0, activation_select_o, use_sum_o, use_bias_o,
                 save_outputs_o, reuse_weights_o, reuse_inputs_o},
                shift_amount_o, base_address_o, result_address_o};
    endfunction

    function automatic bit [255:0] cfg_exp(input int l);
        return {mem[l*8+0], mem[l*8+1], mem[l*8+2], mem[l*8+3],
                mem[l*8+4] & 32'h0000_003F, mem[l*8+5], mem[l*8+6], mem[l*8+7]};
    endfunction

    // Descriptor memory: request acceptance and delayed response.
    always @(negedge clk) begin : mem_model
        int idx;
        if (!rst_n) pend = 1'b0;
        desc_rsp_valid_i = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                desc_rsp_valid_i = 1'b1;
                desc_rsp_data_i  = pend_data;
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        desc_req_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rst_n && desc_req_valid_o && desc_req_ready_i) begin
            acc_cnt++;
            chk("desc_addr", desc_req_addr_o,
                (exp_addr.size() != 0) ? exp_addr.pop_front() : 32'hDEAD_BEEF);
            idx       = int'(((desc_req_addr_o - TBASE) >> 2) & 32'h3F);
            pend      = 1'b1;
            pend_cnt  = (rsp_max != 0) ? $urandom_range(0, rsp_max) : rsp_fixed;
            pend_data = mem[idx];
        end
    end

    // NPU: config scoreboard at exec handshake, stability while valid.
    always @(negedge clk) begin : npu_model
        npu_finished_i = 1'b0;
        if (fin_pend) begin
            if (fin_left == 0) begin
                npu_finished_i = 1'b1;
                fin_pend = 1'b0;
                fin_cyc  = cyc;
            end else begin
                fin_left--;
            end
        end
        if (exec_valid_o && !prev_ev) exec_rise_cyc = cyc;
        prev_ev = exec_valid_o;
        if (exec_valid_o)
            chk("cfg_at_exec", cfg_now(), (exp_cfg.size() != 0) ? exp_cfg[0] : {256{1'b1}});
        exec_ready_i = exec_hold ? 1'b0 : (exec_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (rst_n && exec_valid_o && exec_ready_i) begin
            exec_cnt++;
            if (exp_cfg.size() != 0) void'(exp_cfg.pop_front());
            fin_pend = 1'b1;
            fin_left = (fin_max != 0) ? $urandom_range(0, fin_max) : fin_fixed;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill_layer(input int l, input bit last);
        for (int k = 0; k < 8; k++) mem[l*8+k] = $urandom;
        mem[l*8+4] = (mem[l*8+4] & 32'h7FFF_FFFF) | (last ? 32'h8000_0000 : 32'h0);
    endtask

    task automatic push_layer(input int l);
        for (int k = 0; k < 8; k++) exp_addr.push_back(TBASE + 32'(32*l) + 32'(4*k));
        exp_cfg.push_back(cfg_exp(l));
    endtask

    task automatic do_start(input bit [15:0] cnt);
        @(negedge clk);
        table_base_i  = TBASE;
        layer_count_i = cnt;
        start_i       = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done_o) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk(tag, done_o, 1'b1);
        @(negedge clk);
        chk({tag, "_pulse_end"}, {done_o, busy_o}, 2'b00);
    endtask

    initial begin : stim
        int dcyc, ex0, acc0, ndone;
        bit seen_req;
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        table_base_i = 32'd0; layer_count_i = 16'd0;
        desc_req_ready_i = 1'b0; desc_rsp_valid_i = 1'b0; desc_rsp_data_i = 32'd0;
        exec_ready_i = 1'b0; npu_finished_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_status", {busy_o, done_o, desc_req_valid_o, exec_valid_o}, 4'b0);
        chk("rst_layers_done", layers_done_o, 16'd0);
        chk("rst_cfg", cfg_now(), 256'd0);
        rst_n = 1'b1;

        // Single layer, exact timing
        mem[0] = 4; mem[1] = 4; mem[2] = 4; mem[3] = 4;
        mem[4] = 32'h29; mem[5] = 3; mem[6] = 32'h2000; mem[7] = 32'h3000;
        push_layer(0);
        ex0 = exec_cnt;
        do_start(16'd1);
        chk("t1_req_after_start", {desc_req_valid_o, desc_req_addr_o}, {1'b1, TBASE});
        wait_done("t1_done", dcyc);
        chk("t1_exec_latency", exec_rise_cyc - start_cyc, 16);
        chk("t1_done_after_fin", dcyc, fin_cyc + 1);
        chk("t1_layers_done", layers_done_o, 16'd1);
        chk("t1_exec_count", exec_cnt - ex0, 1);
        chk("t1_rows_shift", {num_input_rows_o, shift_amount_o}, {32'd4, 32'd3});
        chk("t1_flags", {reuse_inputs_o, reuse_weights_o, save_outputs_o, use_bias_o,
                         use_sum_o, activation_select_o}, 6'b100101);
        chk("t1_queues_empty", exp_addr.size() + exp_cfg.size(), 0);

        // Three layers with random stalls
        for (int l = 0; l < 3; l++) fill_layer(l, 1'b0);
        for (int l = 0; l < 3; l++) push_layer(l);
        rdy_rand = 1'b1; rsp_max = 3; exec_rand = 1'b1; fin_max = 4;
        ex0 = exec_cnt;
        do_start(16'd3);
        wait_done("t2_done", dcyc);
        chk("t2_exec_count", exec_cnt - ex0, 3);
        chk("t2_layers_done", layers_done_o, 16'd3);
        chk("t2_queues_empty", exp_addr.size() + exp_cfg.size(), 0);
        rdy_rand = 1'b0; rsp_max = 0; exec_rand = 1'b0; fin_max = 0;

        // Count 5, last flag on second layer
        for (int l = 0; l < 5; l++) fill_layer(l, l == 1);
        push_layer(0); push_layer(1);
        ex0 = exec_cnt;
        do_start(16'd5);
        wait_done("t3_done", dcyc);
        chk("t3_layers_done", layers_done_o, 16'd2);
        chk("t3_exec_count", exec_cnt - ex0, 2);
        chk("t3_queues_empty", exp_addr.size() + exp_cfg.size(), 0);

        // Zero layer count
        @(negedge clk);
        layer_count_i = 16'd0;
        start_i = 1'b1;
        ndone = 0; seen_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            ndone += int'(done_o);
            seen_req |= desc_req_valid_o;
        end
        chk("t4_done_pulses", ndone, 1);
        chk("t4_no_fetch", seen_req, 1'b0);
        chk("t4_idle", busy_o, 1'b0);

        // Abort while waiting for a response; late response ignored
        fill_layer(0, 1'b0);
        push_layer(0);
        rsp_fixed = 6;
        ex0 = exec_cnt; acc0 = acc_cnt;
        do_start(16'd1);
        for (int i = 0; i < 20 && acc_cnt == acc0; i++) @(negedge clk);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("t5_abort_done", done_o, 1'b1);
        seen_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen_req |= desc_req_valid_o | busy_o;
        end
        chk("t5_quiet_after_abort", seen_req, 1'b0);
        chk("t5_no_exec", exec_cnt - ex0, 0);
        chk("t5_layers_done", layers_done_o, 16'd0);
        exp_addr.delete(); exp_cfg.delete();
        rsp_fixed = 0;

        // Abort while running: done waits for finished
        fill_layer(0, 1'b0);
        push_layer(0);
        fin_fixed = 8;
        ex0 = exec_cnt;
        do_start(16'd3);
        for (int i = 0; i < 100 && exec_cnt == ex0; i++) @(negedge clk);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        wait_done("t6_done", dcyc);
        chk("t6_done_after_fin", dcyc, fin_cyc + 1);
        chk("t6_layers_done", layers_done_o, 16'd1);
        chk("t6_queues_empty", exp_addr.size() + exp_cfg.size(), 0);
        fin_fixed = 0;

        // Asynchronous reset during ISSUE, then clean rerun
        fill_layer(0, 1'b0);
        push_layer(0);
        exec_hold = 1'b1;
        do_start(16'd2);
        for (int i = 0; i < 100 && !exec_valid_o; i++) @(negedge clk);
        chk("t7_reached_issue", exec_valid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_exec_drop", {exec_valid_o, busy_o, desc_req_valid_o}, 3'b000);
        chk("t7_rst_cfg", cfg_now(), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exec_hold = 1'b0;
        exp_addr.delete(); exp_cfg.delete();
        fill_layer(0, 1'b0);
        push_layer(0);
        ex0 = exec_cnt;
        do_start(16'd1);
        chk("t7_rerun_addr", desc_req_addr_o, TBASE);
        wait_done("t7_done", dcyc);
        chk("t7_layers_done", layers_done_o, 16'd1);
        chk("t7_exec_count", exec_cnt - ex0, 1);
        chk("t7_queues_empty", exp_addr.size() + exp_cfg.size(), 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
